// File: rtl/imem_fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: default widths,
// the default halt instruction and the controller state encoding.
package imem_fetch_pkg;

   localparam int IMEM_ADDR_W = 8;
   localparam int IMEM_DATA_W = 16;
   localparam logic [IMEM_DATA_W-1:0] IMEM_HALT_WORD = 16'hFFFF;

   // Encoding is visible on the state port, so the values are fixed.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FETCH    = 2'd1,
      RUN_WAIT = 2'd2,
      HALT     = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/imem_fetch_ctrl_step_sync.sv
// Pushbutton conditioning: per bit, a two-flop synchronizer followed by a
// rising-edge detector. The pulse is one clk cycle wide per press, so a held
// button produces only one pulse. Kept generic in width for other KEY inputs.
module step_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] key_in,
   output logic [WIDTH-1:0] key_pulse
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic ff1_reg;
         logic ff2_reg;
         logic ff3_reg;

         // Synchronize the raw level and keep one delayed copy for edge detection.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               ff1_reg <= 1'b0;
               ff2_reg <= 1'b0;
               ff3_reg <= 1'b0;
            end else begin
               ff1_reg <= key_in[gi];
               ff2_reg <= ff1_reg;
               ff3_reg <= ff2_reg;
            end
         end

         assign key_pulse[gi] = ff2_reg & ~ff3_reg;
      end
   endgenerate

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, addresses the instruction memory,
// latches the returned word and sequences fetches either one per button press
// or at a fixed cadence while run_en is high. Stops on a breakpoint address or
// on the halt instruction.
module imem_fetch_ctrl
   import imem_fetch_pkg::*;
#(
   parameter int                 ADDR_W    = IMEM_ADDR_W,
   parameter int                 DATA_W    = IMEM_DATA_W,
   parameter int                 TICK_DIV  = 4,
   parameter logic [DATA_W-1:0]  HALT_WORD = DATA_W'(IMEM_HALT_WORD)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              step_req,
   input  logic              run_en,
   input  logic              bp_en,
   input  logic [ADDR_W-1:0] bp_addr,
   input  logic              jump_valid,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic              halted,
   output logic [1:0]        state,
   output logic [15:0]       fetch_cnt
);

   // FETCH itself and the final zero-count RUN_WAIT cycle account for two of
   // the TICK_DIV cycles, so the counter is loaded with TICK_DIV-2. Values of
   // TICK_DIV below 2 are not legal; they are clamped to behave like 2.
   localparam int WAIT_LOAD = (TICK_DIV > 2) ? (TICK_DIV - 2) : 0;
   localparam int CNT_W     = (WAIT_LOAD > 1) ? $clog2(WAIT_LOAD + 1) : 1;

   fetch_state_t      state_reg;
   logic [ADDR_W-1:0] pc_reg;
   logic [ADDR_W-1:0] pc_next;
   logic [DATA_W-1:0] instr_reg;
   logic              instr_valid_reg;
   logic              halted_reg;
   logic              bp_suppress_reg;
   logic [CNT_W-1:0]  wait_cnt_reg;
   logic [15:0]       fetch_cnt_reg;
   logic              step_pulse;
   logic              halt_hit;
   logic              bp_hit;

   step_sync #(
      .WIDTH(1)
   ) u_step_sync (
      .clk      (clk),
      .reset    (reset),
      .key_in   (step_req),
      .key_pulse(step_pulse)
   );

   // Next PC and stop conditions only matter during FETCH; they are cheap
   // enough to evaluate every cycle. The breakpoint compares against the PC we
   // are about to move to, so the breakpoint address itself is never fetched.
   assign pc_next  = jump_valid ? jump_addr : pc_reg + ADDR_W'(1);
   assign halt_hit = (imem_data == HALT_WORD);
   assign bp_hit   = bp_en && (pc_next == bp_addr) && !bp_suppress_reg;

   // Fetch sequencer: state, PC, fetched word, wait counter and fetch count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         pc_reg          <= '0;
         instr_reg       <= '0;
         instr_valid_reg <= 1'b0;
         halted_reg      <= 1'b0;
         bp_suppress_reg <= 1'b0;
         wait_cnt_reg    <= '0;
         fetch_cnt_reg   <= '0;
      end else begin
         instr_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (step_pulse || run_en) begin
                  state_reg <= FETCH;
               end
            end
            FETCH: begin
               instr_reg       <= imem_data;
               instr_valid_reg <= 1'b1;
               fetch_cnt_reg   <= fetch_cnt_reg + 16'd1;
               pc_reg          <= pc_next;
               // A resume from HALT skips only the breakpoint check of this fetch.
               bp_suppress_reg <= 1'b0;
               if (halt_hit || bp_hit) begin
                  state_reg  <= HALT;
                  halted_reg <= 1'b1;
               end else if (run_en) begin
                  state_reg    <= RUN_WAIT;
                  wait_cnt_reg <= CNT_W'(WAIT_LOAD);
               end else begin
                  state_reg <= IDLE;
               end
            end
            RUN_WAIT: begin
               if (!run_en) begin
                  state_reg <= IDLE;
               end else if (wait_cnt_reg == '0) begin
                  state_reg <= FETCH;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg - CNT_W'(1);
               end
            end
            HALT: begin
               // Only a button press leaves HALT; run_en alone keeps us here.
               if (step_pulse) begin
                  state_reg       <= FETCH;
                  halted_reg      <= 1'b0;
                  bp_suppress_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign imem_addr   = pc_reg;
   assign pc          = pc_reg;
   assign instr       = instr_reg;
   assign instr_valid = instr_valid_reg;
   assign halted      = halted_reg;
   assign state       = state_reg;
   assign fetch_cnt   = fetch_cnt_reg;

endmodule
